// File: rtl/fft_pkg.sv
// Shared constants for the MultimodeFFT datapath: default sample width and
// two's-complement saturation limits expressed as functions of the width.
package fft_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Largest positive value of a w-bit signed number, zero-extended to 64 bits.
    function automatic logic [63:0] max_pos(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative value of a w-bit signed number, sign-extended to 64 bits.
    function automatic logic [63:0] min_neg(input int unsigned w);
        return ~64'd0 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Single-component signed adder with overflow detect. Define
// COMPLEX_ADDER_SAT_EN to clamp on overflow; otherwise the result wraps.
module sat_add
    import fft_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH:0] s;

`ifdef COMPLEX_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));
`endif

    always_comb begin
        s   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        ovf = s[WIDTH] ^ s[WIDTH-1];
`ifdef COMPLEX_ADDER_SAT_EN
        // s[WIDTH] is the true sign of the sum, so it picks the clamp direction.
        if (ovf) begin
            result = s[WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            result = s[WIDTH-1:0];
        end
`else
        result = s[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/fft_complex_adder.sv
// Registered complex adder for the butterfly stage. Saturating vs. wrapping
// behaviour is chosen at compile time with COMPLEX_ADDER_SAT_EN.
module fft_complex_adder
    import fft_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_real,
    input  logic [WIDTH-1:0] a_imag,
    input  logic [WIDTH-1:0] b_real,
    input  logic [WIDTH-1:0] b_imag,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum_real,
    output logic [WIDTH-1:0] sum_imag,
    output logic             overflow
);

    // Handshake: in_valid qualifies the operands at a rising edge and there is
    // no back-pressure, so every valid sample is accepted; out_valid marks the
    // registered result of that sample for the following cycle only.

    logic [WIDTH-1:0] real_res;
    logic [WIDTH-1:0] imag_res;
    logic             real_ovf;
    logic             imag_ovf;

    sat_add #(.WIDTH(WIDTH)) u_real (
        .a      (a_real),
        .b      (b_real),
        .result (real_res),
        .ovf    (real_ovf)
    );

    sat_add #(.WIDTH(WIDTH)) u_imag (
        .a      (a_imag),
        .b      (b_imag),
        .result (imag_res),
        .ovf    (imag_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum_real  <= '0;
            sum_imag  <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Result registers hold their last value across idle cycles.
            if (in_valid) begin
                sum_real <= real_res;
                sum_imag <= imag_res;
                overflow <= real_ovf | imag_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fft_complex_adder.sv
// Directed scoreboard bench for fft_complex_adder; expected values follow
// the build (COMPLEX_ADDER_SAT_EN defined or not).
module tb_fft_complex_adder;

    localparam int W = 16;
    localparam int EW = 2 * W + 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a_real, a_imag, b_real, b_imag;
    logic         out_valid;
    logic [W-1:0] sum_real, sum_imag;
    logic         overflow;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    fft_complex_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a_real    (a_real),
        .a_imag    (a_imag),
        .b_real    (b_real),
        .b_imag    (b_imag),
        .out_valid (out_valid),
        .sum_real  (sum_real),
        .sum_imag  (sum_imag),
        .overflow  (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got ovf=%0b re=%0d im=%0d, want ovf=%0b re=%0d im=%0d", name,
                     got[EW-1], $signed(got[EW-2:W]), $signed(got[W-1:0]),
                     exp[EW-1], $signed(exp[EW-2:W]), $signed(exp[W-1:0]));
        end
    endtask

    function automatic logic [EW-1:0] pack(input int er, input int ei, input bit eo);
        logic [W-1:0] r;
        logic [W-1:0] i;
        r = W'(er);
        i = W'(ei);
        return {eo, r, i};
    endfunction

    // driver tasks
    task automatic drive(input int ar, input int br, input int ai, input int bi);
        a_real   = W'(ar);
        b_real   = W'(br);
        a_imag   = W'(ai);
        b_imag   = W'(bi);
        in_valid = 1'b1;
    endtask

    task automatic send(input int ar, input int br, input int ai, input int bi,
                        input int er, input int ei, input bit eo);
        drive(ar, br, ai, bi);
        exp_q.push_back(pack(er, ei, eo));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got out_valid=1 re=%0d, want no output",
                         $signed(sum_real));
            end else begin
                check("result", {overflow, sum_real, sum_imag}, exp_q.pop_front());
            end
        end
    end

    initial begin : stim
        int ov_r1, ov_r2, ov_i1, big_r;
        logic [EW-1:0] zero_out;
        zero_out = '0;
`ifdef COMPLEX_ADDER_SAT_EN
        ov_r1 = 32767;  ov_r2 = 32767;  ov_i1 = -32768; big_r = -32768;
`else
        ov_r1 = -16385; ov_r2 = -32768; ov_i1 = 32767;  big_r = 25536;
`endif
        rst_n = 1'b0;
        idle();
        a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;

        // reset held with random valid inputs
        for (int k = 0; k < 3; k++) begin
            drive($urandom_range(0, 65535), $urandom_range(0, 65535),
                  $urandom_range(0, 65535), $urandom_range(0, 65535));
            @(negedge clk);
            check("reset_hold", {overflow, sum_real, sum_imag}, zero_out);
            check("reset_valid", {31'd0, out_valid, 1'b0}, '0);
        end
        #2 rst_n = 1'b1;

        send(100, 200, 0, 0, 300, 0, 1'b0);
        send(32767, 16384, 0, 0, ov_r1, 0, 1'b1);
        send(16384, 16384, 0, 0, ov_r2, 0, 1'b1);
        send(16383, 16384, 0, 0, 32767, 0, 1'b0);
        send(5, 5, -32768, -1, 10, ov_i1, 1'b1);
        send(-16384, -16384, 0, 0, -32768, 0, 1'b0);

        // three back-to-back, then idle and hold
        send(1, 3, 2, 4, 4, 6, 1'b0);
        send(-7, 3, 10, -20, -4, -10, 1'b0);
        send(-20000, -20000, 1000, -1000, big_r, 0, 1'b1);
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("hold_valid", {31'd0, out_valid, 1'b0}, '0);
        check("hold_value", {overflow, sum_real, sum_imag}, pack(big_r, 0, 1'b1));

        // mid-stream reset: second sample is never emitted
        send(7, 8, 9, 10, 15, 19, 1'b0);
        drive(1000, 1000, 1000, 1000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_clear", {overflow, sum_real, sum_imag, out_valid}, {zero_out, 1'b0});
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_midstream", {overflow, sum_real, sum_imag, out_valid}, {zero_out, 1'b0});
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        #1;
        send(1, 1, 2, 2, 2, 4, 1'b0);
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;

        // drain with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
